// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 shift-add multiplier that owns the Hi/Lo register pair.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, sgn, a, b   : launch MULT (sgn=1) / MULTU (sgn=0), sampled while idle
//   mthi, mtlo, wdata  : direct writes into Hi/Lo, honoured only while idle
//   busy               : multiply in progress (32 cycles)
//   done               : one-cycle pulse after Hi/Lo receive a product
//   hi, lo             : architectural Hi/Lo registers
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [2*DW-1:0] r_acc;
    logic [DW-1:0]   r_mcand;
    logic            r_neg;
    logic            r_busy;
    logic            r_done;
    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;

    logic            w_idle;
    logic            w_accept;
    logic            w_last;
    logic [DW-1:0]   w_mag_a;
    logic [DW-1:0]   w_mag_b;
    logic [DW:0]     w_sum;
    logic [2*DW-1:0] w_acc_nxt;
    logic [2*DW-1:0] w_prod;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && start;
    assign w_last   = (r_state == RUN) && (r_count == CW'(DW - 1));

    // Signed operands run as magnitudes; 0x80000000 negates to itself, which is its unsigned magnitude.
    assign w_mag_a = (sgn && a[DW-1]) ? (~a + DW'(1)) : a;
    assign w_mag_b = (sgn && b[DW-1]) ? (~b + DW'(1)) : b;

    // Upper half plus carry; the carry bit lands in bit 63 after the shift.
    assign w_sum     = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, r_mcand};
    assign w_acc_nxt = r_acc[0] ? {w_sum, r_acc[DW-1:1]} : {1'b0, r_acc[2*DW-1:1]};
    assign w_prod    = r_neg ? (~w_acc_nxt + (2*DW)'(1)) : w_acc_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Multiply datapath and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_count <= '0;
                r_acc   <= {DW'(0), w_mag_b};
                r_mcand <= w_mag_a;
                r_neg   <= sgn && (a[DW-1] ^ b[DW-1]);
                r_busy  <= 1'b1;
            end else if (r_state == RUN) begin
                r_count <= r_count + CW'(1);
                r_acc   <= w_acc_nxt;
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Hi/Lo: product write at completion, otherwise moves while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_prod[2*DW-1:DW];
            r_lo <= w_prod[DW-1:0];
        end else if (w_idle) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected {hi,lo} products,
// a monitor pops and compares on every done pulse.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;
    int busy_cnt = 0;
    logic [63:0] exp_q[$];

    hilo_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    // Monitor: compares Hi/Lo and busy length whenever a product is reported.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_excl_busy", {63'd0, busy}, 64'd0);
                check("busy_cycles", 64'(busy_cnt), 64'd32);
                busy_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", {hi, lo}, e);
                end
            end
            if (!rst_n) busy_cnt = 0;
            else if (busy) busy_cnt++;
        end
    end

    // Issue a start on the next edge; push the expectation only when it should be accepted.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                         input logic [63:0] exp, input logic expect_accept);
        @(negedge clk);
        a = ta; b = tb_; sgn = ts; start = 1'b1;
        if (expect_accept) exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) check(name, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_done("to_umax");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
        wait_done("to_sm1");
        issue(32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1);
        wait_done("to_smin");
        issue(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        wait_done("to_7m3");
        issue(32'h0000_0000, 32'h1234_5678, 1'b0, 64'd0, 1'b1);
        wait_done("to_zero");

        // Start and MTHI while running are both dropped.
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        repeat (5) @(negedge clk);
        issue(32'h0000_1111, 32'h0000_2222, 1'b0, 64'd0, 1'b0);
        @(negedge clk);
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        @(negedge clk);
        check("mthi_ignored_busy", {32'd0, hi}, 64'd0);
        wait_done("to_busy_ignore");

        // Moves alone in idle.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h1357_9BDF;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_only", {hi, lo}, 64'hA5A5_A5A5_1357_9BDF);

        // Moves together with a start: moves land now, product later.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        a = 32'd3; b = 32'd4; sgn = 1'b0; start = 1'b1;
        exp_q.push_back(64'h0000_0000_0000_000C);
        @(posedge clk);
        #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        check("move_with_start", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
        repeat (20) @(negedge clk);
        check("move_held_midrun", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
        wait_done("to_move_start");

        // Asynchronous reset mid-multiply aborts it.
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0, 1'b1);
        repeat (15) @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd5, 32'd5, 1'b0, 64'h0000_0000_0000_0019, 1'b1);
        wait_done("to_after_reset");

        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
